// File: rtl/test_ctrl_pkg.sv
// test_ctrl_pkg: sequencer state encoding and default parameters for test_mode_ctrl
package test_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, STOP, SET_SETTLE, TEST, CLR_SETTLE} state_t;
  localparam int KEY_W_D = 16;
  localparam logic [15:0] KEY_D = 16'hA5C3;
  localparam int SETTLE_CYC_D = 8;
  localparam int ACK_TO_D = 64;
endpackage

// File: rtl/test_key_shift.sv
// test_key_shift: serial unlock key register with match against KEY
//   clk, reset : clock, synchronous active-high reset
//   en         : shifting allowed (sequencer idle)
//   stb, sdi   : strobe and serial data, MSB first
//   clr        : clear the register (consumed by a good key_load)
//   key_match  : register equals KEY
module test_key_shift
  import test_ctrl_pkg::*;
#(
  parameter int KEY_W = KEY_W_D,
  parameter logic [KEY_W-1:0] KEY = KEY_W'(KEY_D)
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic stb,
  input  logic sdi,
  input  logic clr,
  output logic key_match
);
  logic [KEY_W-1:0] key;
  always_ff @(posedge clk) begin
    if (reset || clr) key <= '0;
    else if (en && stb) key <= {key[KEY_W-2:0], sdi};
  end
  assign key_match = key == KEY;
endmodule

// File: rtl/test_mode_ctrl.sv
// test_mode_ctrl: key-unlocked sequencer that flips the scan mux select only under stopped clocks
//   clk, reset            : clock, synchronous active-high reset
//   key_sdi, key_stb      : serial unlock key input
//   key_load, exit_req    : request test entry / test exit
//   clk_stop_ack          : functional clocks reported stopped
//   clk_stop_req          : request functional clocks stopped
//   test_mode             : mux select, 1 = scan_clk
//   busy                  : sequencing between IDLE and TEST
//   key_err, timeout_err  : sticky error flags
module test_mode_ctrl
  import test_ctrl_pkg::*;
#(
  parameter int KEY_W = KEY_W_D,
  parameter logic [KEY_W-1:0] KEY = KEY_W'(KEY_D),
  parameter int SETTLE_CYC = SETTLE_CYC_D,
  parameter int ACK_TO = ACK_TO_D
) (
  input  logic clk,
  input  logic reset,
  input  logic key_sdi,
  input  logic key_stb,
  input  logic key_load,
  input  logic exit_req,
  input  logic clk_stop_ack,
  output logic clk_stop_req,
  output logic test_mode,
  output logic busy,
  output logic key_err,
  output logic timeout_err
);
  localparam int CNT_W = $clog2((SETTLE_CYC > ACK_TO) ? SETTLE_CYC : ACK_TO) + 1;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic key_match, settle_done, ack_late, idle;
  assign idle = state == IDLE;
  assign settle_done = cnt == CNT_W'(SETTLE_CYC - 1);
  assign ack_late = cnt == CNT_W'(ACK_TO - 1);
  test_key_shift #(.KEY_W(KEY_W), .KEY(KEY)) u_key (
    .clk(clk),
    .reset(reset),
    .en(idle),
    .stb(key_stb),
    .sdi(key_sdi),
    .clr(idle && key_load && key_match),
    .key_match(key_match)
  );
  // Every transition below also clears cnt so each state times from its own entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      clk_stop_req <= 1'b0;
      test_mode <= 1'b0;
      busy <= 1'b0;
      key_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cnt <= &cnt ? cnt : cnt + 1'b1;
      case (state)
        IDLE: if (key_load) begin
          key_err <= !key_match;
          if (key_match) begin
            state <= STOP;
            cnt <= '0;
            clk_stop_req <= 1'b1;
            busy <= 1'b1;
          end
        end
        // An abort takes priority over a same-cycle ack: the select has not moved yet.
        STOP: if (exit_req) begin
          state <= CLR_SETTLE;
          cnt <= '0;
        end else if (clk_stop_ack) begin
          state <= SET_SETTLE;
          cnt <= '0;
        end else if (ack_late) begin
          state <= IDLE;
          cnt <= '0;
          clk_stop_req <= 1'b0;
          busy <= 1'b0;
          timeout_err <= 1'b1;
        end
        SET_SETTLE: if (exit_req || !clk_stop_ack) begin
          state <= CLR_SETTLE;
          cnt <= '0;
        end else if (settle_done) begin
          state <= TEST;
          cnt <= '0;
          test_mode <= 1'b1;
          busy <= 1'b0;
        end
        // Losing ack in TEST is a fault: drop the select but keep req through the settle window.
        TEST: if (exit_req || !clk_stop_ack) begin
          state <= CLR_SETTLE;
          cnt <= '0;
          test_mode <= 1'b0;
          busy <= 1'b1;
        end
        CLR_SETTLE: if (settle_done) begin
          state <= IDLE;
          cnt <= '0;
          clk_stop_req <= 1'b0;
          busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_test_mode_ctrl.sv
// tb_test_mode_ctrl: randomized scenarios with a change-event scoreboard for test_mode_ctrl
module tb_test_mode_ctrl;
  localparam int S = 8;
  localparam int TO = 64;
  localparam logic [15:0] K = 16'hA5C3;
  logic clk = 1'b0;
  logic reset, key_sdi, key_stb, key_load, exit_req, clk_stop_ack;
  logic clk_stop_req, test_mode, busy, key_err, timeout_err;
  test_mode_ctrl #(.KEY_W(16), .KEY(K), .SETTLE_CYC(S), .ACK_TO(TO)) dut (
    .clk(clk),
    .reset(reset),
    .key_sdi(key_sdi),
    .key_stb(key_stb),
    .key_load(key_load),
    .exit_req(exit_req),
    .clk_stop_ack(clk_stop_ack),
    .clk_stop_req(clk_stop_req),
    .test_mode(test_mode),
    .busy(busy),
    .key_err(key_err),
    .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // Expected output changes: {test_mode, clk_stop_req, busy, key_err, timeout_err} at edge c.
  typedef struct {int c; logic [4:0] v;} ev_t;
  ev_t q[$];
  logic [4:0] ev = 5'b0;
  function automatic void expect_at(int c, logic [4:0] v);
    if (v != ev) q.push_back('{c, v});
    ev = v;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_until(int n);
    while (cyc < n) step();
  endtask
  task automatic shift_key(logic [15:0] k);
    for (int i = 15; i >= 0; i--) begin
      if ($urandom_range(0, 3) == 0) begin
        key_stb = 1'b0;
        key_sdi = 1'($urandom);
        step();
      end
      key_stb = 1'b1;
      key_sdi = k[i];
      step();
    end
    key_stb = 1'b0;
  endtask
  task automatic round();
    logic [15:0] k;
    logic good;
    int l, a, x, mode;
    good = $urandom_range(0, 2) != 0;
    k = good ? K : K ^ 16'($urandom_range(1, 65535));
    shift_key(k);
    key_load = 1'b1;
    exit_req = 1'($urandom);
    l = cyc + 1;
    if (!good) begin
      expect_at(l, {3'b000, 1'b1, ev[0]});
      step();
      key_load = 1'b0;
      exit_req = 1'b0;
      repeat (2) step();
      return;
    end
    expect_at(l, {3'b011, 1'b0, ev[0]});
    step();
    key_load = 1'b0;
    exit_req = 1'b0;
    mode = $urandom_range(0, 6);
    if (mode == 6) begin
      expect_at(l + TO, {3'b000, ev[1], 1'b1});
      wait_until(l + TO + 2);
      return;
    end
    if (mode == 3) begin
      x = l + $urandom_range(1, TO - 1);
      wait_until(x - 1);
      exit_req = 1'b1;
      expect_at(x + S, {3'b000, ev[1:0]});
      step();
      exit_req = 1'b0;
      wait_until(x + S + 2);
      return;
    end
    a = l + 1 + $urandom_range(0, TO - 1);
    wait_until(a - 1);
    clk_stop_ack = 1'b1;
    if (mode <= 1) expect_at(a + S, {3'b110, ev[1:0]});
    step();
    if (mode <= 1) begin
      wait_until(a + S);
      if (mode == 0) shift_key(K);
      repeat ($urandom_range(0, 5)) step();
      x = cyc + 1;
      if (mode == 0) begin
        exit_req = 1'b1;
        key_load = 1'($urandom);
      end else clk_stop_ack = 1'b0;
    end else begin
      x = a + $urandom_range(1, S - 1);
      wait_until(x - 1);
      if (mode == 2) exit_req = 1'b1;
      else if (mode == 4) clk_stop_ack = 1'b0;
      else reset = 1'b1;
    end
    if (mode == 5) begin
      expect_at(x, 5'b0);
      step();
      step();
      reset = 1'b0;
      clk_stop_ack = 1'b0;
      step();
      return;
    end
    if (mode <= 1) expect_at(x, {3'b011, ev[1:0]});
    expect_at(x + S, {3'b000, ev[1:0]});
    step();
    exit_req = 1'b0;
    key_load = 1'b0;
    wait_until(x + S + 2);
    clk_stop_ack = 1'b0;
    if (mode == 0) begin
      // The key shifted during TEST must have been ignored, so a bare load mismatches.
      key_load = 1'b1;
      expect_at(cyc + 1, {3'b000, 1'b1, ev[0]});
      step();
      key_load = 1'b0;
      repeat (2) step();
    end
  endtask
  int tests = 0, fails = 0;
  logic mon_en = 1'b0, started = 1'b0, done = 1'b0;
  logic [4:0] seen, now;
  ev_t e;
  always @(negedge clk) if (mon_en) begin
    now = {test_mode, clk_stop_req, busy, key_err, timeout_err};
    if (!started) begin
      tests++;
      started = 1'b1;
      if (now !== 5'b0) begin
        fails++;
        $display("FAIL reset_state cyc=%0d got=%b want=00000", cyc, now);
      end
    end else if (now !== seen) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change cyc=%0d got=%b want=%b (no change)", cyc, now, seen);
      end else begin
        e = q.pop_front();
        if (e.c != cyc || e.v !== now) begin
          fails++;
          $display("FAIL output_event got=%b@%0d want=%b@%0d", now, cyc, e.v, e.c);
        end
      end
    end else if (q.size() != 0 && q[0].c <= cyc) begin
      tests++;
      fails++;
      e = q.pop_front();
      $display("FAIL missed_event cyc=%0d got=%b want=%b@%0d", cyc, now, e.v, e.c);
    end
    seen = now;
    if (done) begin
      tests++;
      if (q.size() != 0) begin
        fails++;
        $display("FAIL leftover_events got=%0d want=0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end
  a_rise: assert property (@(posedge clk) disable iff (reset)
    $rose(test_mode) |-> $past(clk_stop_req) && $past(clk_stop_ack))
    else $error("FAIL tm_rise_invariant req=%b ack=%b want 1 1", $past(clk_stop_req), $past(clk_stop_ack));
  a_fall: assert property (@(posedge clk) disable iff (reset)
    $fell(test_mode) |-> $past(clk_stop_req))
    else $error("FAIL tm_fall_invariant req=%b want 1", $past(clk_stop_req));
  initial begin
    reset = 1'b1;
    key_sdi = 1'b0;
    key_stb = 1'b0;
    key_load = 1'b0;
    exit_req = 1'b0;
    clk_stop_ack = 1'b0;
    step();
    step();
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (60) round();
    repeat (4) step();
    done = 1'b1;
  end
endmodule
